// File: rtl/quadra_pipe.sv
// quadra_pipe: streaming piecewise-quadratic evaluator y = a + b*x2 + c*x2^2.
// Coefficients come from a run-time programmable table of NFUNC functions x
// 2^SEG_BITS segments. Four register stages, one global stall enable, round
// half-to-even and output saturation. All flops act on the falling clock edge.
module quadra_pipe #(
  parameter int X_W      = 24,
  parameter int SEG_BITS = 7,
  parameter int NFUNC    = 2,
  parameter int A_W      = 30,
  parameter int B_W      = 22,
  parameter int C_W      = 15,
  parameter int Y_W      = 24,
  parameter int Y_ROUND  = 6,
  parameter int TAG_W    = 4,
  parameter int FS_W     = (NFUNC > 1) ? $clog2(NFUNC) : 1
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [X_W-1:0]               in_x,
  input  logic [FS_W-1:0]              in_func,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [Y_W-1:0]        y,
  output logic                         out_sat,
  output logic [TAG_W-1:0]             out_tag,
  input  logic                         cfg_we,
  input  logic [FS_W+SEG_BITS-1:0]     cfg_addr,
  input  logic signed [A_W-1:0]        cfg_a,
  input  logic signed [B_W-1:0]        cfg_b,
  input  logic signed [C_W-1:0]        cfg_c
);

  localparam int F      = X_W - SEG_BITS;
  localparam int ADDR_W = FS_W + SEG_BITS;
  // Power-of-two depth so every {func, seg} code indexes a real entry.
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BX_W   = B_W + F + 1;
  localparam int CX_W   = C_W + 2 * F + 1;
  localparam int SUM_W  = A_W + 2;
  localparam int Q_W    = SUM_W - Y_ROUND;
  localparam int QR_W   = Q_W + 1;

  localparam logic [Y_ROUND-1:0]     HALF  = Y_ROUND'(1) << (Y_ROUND - 1);
  localparam logic signed [QR_W-1:0] Y_MAX = QR_W'((64'sd1 <<< (Y_W - 1)) - 64'sd1);
  localparam logic signed [QR_W-1:0] Y_MIN = QR_W'(-(64'sd1 <<< (Y_W - 1)));

  typedef struct packed {
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
    logic signed [C_W-1:0] c;
  } coef_t;

  coef_t table_mem [DEPTH];

  // Global stall: every stage advances together or holds together.
  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // Stage registers
  logic                    v1, v2, v3;
  logic [ADDR_W-1:0]       addr1;
  logic [F-1:0]            x2_1, x2_2;
  logic [2*F-1:0]          x2sq_2;
  logic [TAG_W-1:0]        tag1, tag2, tag3;
  coef_t                   rd2;
  logic signed [A_W-1:0]   t0_3;
  logic signed [B_W:0]     t1_3;
  logic signed [C_W:0]     t2_3;

  // Coefficient table write port; runs regardless of the stall state.
  // NOTE: the table is deliberately not reset -- it is retained across rst_b and a reset loop would only add muxing to a RAM.
  always_ff @(negedge clk) begin
    if (cfg_we) table_mem[cfg_addr] <= '{a: cfg_a, b: cfg_b, c: cfg_c};
  end

  // S1: split the argument into segment and fraction, form the table address.
  // NOTE: sequential state uses non-blocking assignments so every stage samples the previous stage's pre-edge value.
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      v1    <= 1'b0;
      addr1 <= '0;
      x2_1  <= '0;
      tag1  <= '0;
    end else if (en) begin
      v1    <= in_valid;
      addr1 <= {in_func, in_x[X_W-1:F]};
      x2_1  <= in_x[F-1:0];
      tag1  <= in_tag;
    end
  end

  // S2: registered table read (same-edge write returns the old entry), x2 squared.
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      v2     <= 1'b0;
      rd2    <= '0;
      x2_2   <= '0;
      x2sq_2 <= '0;
      tag2   <= '0;
    end else if (en) begin
      v2     <= v1;
      rd2    <= table_mem[addr1];
      x2_2   <= x2_1;
      x2sq_2 <= (2 * F)'(x2_1) * (2 * F)'(x2_1);
      tag2   <= tag1;
    end
  end

  // S3: the three terms, each product floor-shifted back to coefficient scale.
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      v3   <= 1'b0;
      t0_3 <= '0;
      t1_3 <= '0;
      t2_3 <= '0;
      tag3 <= '0;
    end else if (en) begin
      v3   <= v2;
      t0_3 <= rd2.a;
      t1_3 <= (B_W + 1)'((BX_W'(rd2.b) * BX_W'($signed({1'b0, x2_2}))) >>> F);
      t2_3 <= (C_W + 1)'((CX_W'(rd2.c) * CX_W'($signed({1'b0, x2sq_2}))) >>> (2 * F));
      tag3 <= tag2;
    end
  end

  logic signed [SUM_W-1:0] sum;
  logic signed [Q_W-1:0]   q;
  logic [Y_ROUND-1:0]      rem;
  logic                    rnd_up;
  logic signed [QR_W-1:0]  qr;
  logic signed [Y_W-1:0]   y_d;
  logic                    sat_d;

  // Sum, round half-to-even on the dropped bits, then clip to the output range.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum    = '0;
    q      = '0;
    rem    = '0;
    rnd_up = 1'b0;
    qr     = '0;
    y_d    = '0;
    sat_d  = 1'b0;
    sum    = SUM_W'(t0_3) + SUM_W'(t1_3) + SUM_W'(t2_3);
    q      = sum[SUM_W-1:Y_ROUND];
    rem    = sum[Y_ROUND-1:0];
    rnd_up = (rem > HALF) || ((rem == HALF) && q[0]);
    qr     = QR_W'(q) + QR_W'(rnd_up);
    if (qr > Y_MAX) begin
      y_d   = Y_W'(Y_MAX);
      sat_d = 1'b1;
    end else if (qr < Y_MIN) begin
      y_d   = Y_W'(Y_MIN);
      sat_d = 1'b1;
    end else begin
      y_d   = qr[Y_W-1:0];
    end
  end

  // S4: output register; holds the result while the consumer stalls.
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      y         <= '0;
      out_sat   <= 1'b0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= v3;
      y         <= y_d;
      out_sat   <= sat_d;
      out_tag   <= tag3;
    end
  end

endmodule

// File: tb/tb_quadra_pipe.sv
// Directed self-checking bench for quadra_pipe. The DUT acts on the falling
// edge; the bench drives on the rising edge and samples 2 time units later.
module tb_quadra_pipe;

  localparam int X_W = 24;
  localparam int Y_W = 24;

  logic                clk = 1'b0;
  logic                rst_b;
  logic                in_valid;
  logic                in_ready;
  logic [X_W-1:0]      in_x;
  logic [0:0]          in_func;
  logic [3:0]          in_tag;
  logic                out_valid;
  logic                out_ready;
  logic signed [Y_W-1:0] y;
  logic                out_sat;
  logic [3:0]          out_tag;
  logic                cfg_we;
  logic [7:0]          cfg_addr;
  logic signed [29:0]  cfg_a;
  logic signed [21:0]  cfg_b;
  logic signed [14:0]  cfg_c;

  int n_cmp  = 0;
  int n_fail = 0;

  quadra_pipe dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_func   (in_func),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_sat   (out_sat),
    .out_tag   (out_tag),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_a     (cfg_a),
    .cfg_b     (cfg_b),
    .cfg_c     (cfg_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", name, obs, exp);
    end
  endtask

  task automatic cfg_write(input int func, input int seg, input int a,
                           input int b, input int c);
    @(posedge clk);
    cfg_we   = 1'b1;
    cfg_addr = {func[0], seg[6:0]};
    cfg_a    = a[29:0];
    cfg_b    = b[21:0];
    cfg_c    = c[14:0];
    @(posedge clk);
    cfg_we   = 1'b0;
  endtask

  // One isolated transaction: result must appear exactly 3 edges after accept.
  task automatic run_one(input string name, input int x, input int func,
                         input int tag, input int exp_y, input int exp_sat);
    @(posedge clk);
    in_valid = 1'b1;
    in_x     = x[23:0];
    in_func  = func[0:0];
    in_tag   = tag[3:0];
    #2 check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 check({name, "_early"}, out_valid, 0);
    @(posedge clk);
    #2;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_y"}, y, exp_y);
    check({name, "_sat"}, out_sat, exp_sat);
    check({name, "_tag"}, out_tag, tag);
  endtask

  int a_vec [5] = '{6400, 6432, 6496, 6433, -6432};
  int y_vec [5] = '{100, 100, 102, 101, -100};

  initial begin
    int sent;
    int rx;
    int seen;
    logic prev_stall;
    logic signed [Y_W-1:0] prev_y;
    logic [3:0] prev_tag;

    rst_b     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_func   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_a     = '0;
    cfg_b     = '0;
    cfg_c     = '0;

    // Asynchronous reset between edges: outputs clear with no clock edge.
    #7 rst_b = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    rst_b = 1'b1;

    // Constant term and half-to-even rounding.
    foreach (a_vec[i]) begin
      cfg_write(0, 0, a_vec[i], 0, 0);
      run_one($sformatf("round%0d", i), 0, 0, i, y_vec[i], 0);
    end

    // Linear / quadratic terms and function select.
    cfg_write(0, 0, 0, 4096, 0);
    cfg_write(1, 0, 0, 0, 4096);
    run_one("lin_f0", 32'h010000, 0, 1, 32, 0);
    run_one("quad_f1", 32'h010000, 1, 2, 16, 0);

    // Segment addressing: same segment, different functions.
    cfg_write(0, 5, 576, 0, 0);
    cfg_write(1, 5, 448, 0, 0);
    run_one("seg5_f0", 32'h0A0000, 0, 3, 9, 0);
    run_one("seg5_f1", 32'h0A0000, 1, 4, 7, 0);

    // Mixed signs at full-scale fraction: floor shifts then rounding.
    cfg_write(0, 2, 1000, -2097152, -16384);
    run_one("mix_neg", 32'h05FFFF, 0, 5, -33008, 0);
    cfg_write(1, 3, 0, 0, 16383);
    run_one("c_max", 32'h07FFFF, 1, 6, 256, 0);

    // Saturation and the exact range bounds.
    cfg_write(0, 0, 536870911, 0, 0);
    run_one("sat_hi", 0, 0, 7, 8388607, 1);
    cfg_write(0, 0, 536870848, 0, 0);
    run_one("edge_hi", 0, 0, 8, 8388607, 0);
    cfg_write(0, 0, -536870912, 0, 0);
    run_one("edge_lo", 0, 0, 9, -8388608, 0);
    cfg_write(0, 0, -536870912, -4096, 0);
    run_one("sat_lo", 32'h010000, 0, 10, -8388608, 1);

    // Backpressure: 8-item stream, y = 10 + tag, 5-cycle output stall mid-stream.
    cfg_write(0, 0, 640, 8192, 0);
    sent = 0;
    rx = 0;
    prev_stall = 1'b0;
    prev_y = '0;
    prev_tag = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      out_ready = !(cyc >= 5 && cyc < 10);
      in_valid  = (sent < 8);
      in_x      = 24'(sent * 1024);
      in_func   = '0;
      in_tag    = 4'(sent);
      #2;
      if (prev_stall) begin
        check("bp_hold_y", y, prev_y);
        check("bp_hold_tag", out_tag, prev_tag);
      end
      if (out_valid && !out_ready) check("bp_in_ready_low", in_ready, 0);
      if (out_valid && out_ready) begin
        if (rx < 8) begin
          check($sformatf("bp_tag%0d", rx), out_tag, rx);
          check($sformatf("bp_y%0d", rx), y, 10 + rx);
        end else begin
          check("bp_extra_result", rx, 7);
        end
        rx++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      prev_tag   = out_tag;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", sent, 8);
    check("bp_received", rx, 8);

    // Read/write collision: A reads seg0 on the write edge (old), B after (new).
    cfg_write(0, 0, 0, 0, 0);
    @(posedge clk);
    in_valid = 1'b1;
    in_x     = '0;
    in_func  = '0;
    in_tag   = 4'hA;
    #2 check("col_in_ready", in_ready, 1);
    @(posedge clk);
    in_tag   = 4'hB;
    cfg_we   = 1'b1;
    cfg_addr = '0;
    cfg_a    = 30'sd6400;
    cfg_b    = '0;
    cfg_c    = '0;
    @(posedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    @(posedge clk);
    #2 check("col_early", out_valid, 0);
    @(posedge clk);
    #2;
    check("col_old_valid", out_valid, 1);
    check("col_old_y", y, 0);
    check("col_old_tag", out_tag, 4'hA);
    @(posedge clk);
    #2;
    check("col_new_valid", out_valid, 1);
    check("col_new_y", y, 100);
    check("col_new_tag", out_tag, 4'hB);

    // Reset with two transactions in flight: they vanish, the table stays.
    @(posedge clk);
    in_valid = 1'b1;
    in_tag   = 4'hC;
    @(posedge clk);
    in_tag   = 4'hD;
    @(posedge clk);
    in_valid = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    @(posedge clk);
    rst_b = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2 if (out_valid) seen++;
    end
    check("rst2_flushed", seen, 0);
    run_one("retain", 0, 0, 5, 100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
